// File: rtl/mod_butterfly_pipe.sv
// Multi-lane modular add/sub butterfly, stallable two-stage pipeline with bypass mode.
// Optional macro MOD_HALVE_EN adds in_halve and a third stage that multiplies results by 2^-1 mod Q.
module mod_butterfly_pipe #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
`ifdef MOD_HALVE_EN
  input  logic                   in_halve,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_sum,
  output logic [LANES*WIDTH-1:0] out_diff
);

  localparam int              W1 = WIDTH + 1;
  localparam logic [W1-1:0]   QW = W1'(Q);

  // Handshake: a beat moves on a rising edge when valid & ready. Each stage advances when it is
  // empty or the stage after it advances; ready depends only on registered state and out_ready.
  logic adv1, adv2;

  logic                   s1_valid_q, s1_mode_q;
  logic [LANES*W1-1:0]    s1_sum_q, s1_sum_d, s1_diff_q, s1_diff_d;
  logic                   s2_valid_q;
  logic [LANES*WIDTH-1:0] s2_sum_q, s2_sum_d, s2_diff_q, s2_diff_d;

  always_comb begin
    s1_sum_d  = '0;
    s1_diff_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_mode) begin
        s1_sum_d[i*W1 +: W1]  = {1'b0, in_a[i*WIDTH +: WIDTH]};
        s1_diff_d[i*W1 +: W1] = {1'b0, in_b[i*WIDTH +: WIDTH]};
      end else begin
        s1_sum_d[i*W1 +: W1]  = {1'b0, in_a[i*WIDTH +: WIDTH]} + {1'b0, in_b[i*WIDTH +: WIDTH]};
        s1_diff_d[i*W1 +: W1] = {1'b0, in_a[i*WIDTH +: WIDTH]} - {1'b0, in_b[i*WIDTH +: WIDTH]};
      end
    end
  end

  // Raw sum lies in [0,2Q) and raw diff in (-Q,Q); one conditional correction lands both in [0,Q).
  always_comb begin
    s2_sum_d  = '0;
    s2_diff_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_mode_q) begin
        s2_sum_d[i*WIDTH +: WIDTH]  = s1_sum_q[i*W1 +: WIDTH];
        s2_diff_d[i*WIDTH +: WIDTH] = s1_diff_q[i*W1 +: WIDTH];
      end else begin
        s2_sum_d[i*WIDTH +: WIDTH]  = (s1_sum_q[i*W1 +: W1] >= QW) ?
                                      WIDTH'(s1_sum_q[i*W1 +: W1] - QW) : s1_sum_q[i*W1 +: WIDTH];
        s2_diff_d[i*WIDTH +: WIDTH] = s1_diff_q[i*W1 + WIDTH] ?
                                      WIDTH'(s1_diff_q[i*W1 +: W1] + QW) : s1_diff_q[i*W1 +: WIDTH];
      end
    end
  end

`ifdef MOD_HALVE_EN
  logic                   adv3;
  logic                   s1_halve_q, s2_halve_q;
  logic                   s3_valid_q;
  logic [LANES*WIDTH-1:0] s3_sum_q, s3_sum_d, s3_diff_q, s3_diff_d;

  function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] x);
    logic [W1-1:0] t;
    t = {1'b0, x} + (x[0] ? QW : '0);
    return WIDTH'(t >> 1);
  endfunction

  always_comb begin
    s3_sum_d  = s2_sum_q;
    s3_diff_d = s2_diff_q;
    if (s2_halve_q) begin
      for (int i = 0; i < LANES; i++) begin
        s3_sum_d[i*WIDTH +: WIDTH]  = halve_mod(s2_sum_q[i*WIDTH +: WIDTH]);
        s3_diff_d[i*WIDTH +: WIDTH] = halve_mod(s2_diff_q[i*WIDTH +: WIDTH]);
      end
    end
  end

  assign adv3      = !s3_valid_q | out_ready;
  assign adv2      = !s2_valid_q | adv3;
  assign out_valid = s3_valid_q;
  assign out_sum   = s3_sum_q;
  assign out_diff  = s3_diff_q;
`else
  assign adv2      = !s2_valid_q | out_ready;
  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_diff  = s2_diff_q;
`endif

  assign adv1     = !s1_valid_q | adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_sum_q   <= '0;
      s1_diff_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_diff_q  <= '0;
`ifdef MOD_HALVE_EN
      s1_halve_q <= 1'b0;
      s2_halve_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_sum_q   <= '0;
      s3_diff_q  <= '0;
`endif
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_mode_q <= in_mode;
          s1_sum_q  <= s1_sum_d;
          s1_diff_q <= s1_diff_d;
`ifdef MOD_HALVE_EN
          s1_halve_q <= in_halve & ~in_mode;
`endif
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sum_q  <= s2_sum_d;
          s2_diff_q <= s2_diff_d;
`ifdef MOD_HALVE_EN
          s2_halve_q <= s1_halve_q;
`endif
        end
      end
`ifdef MOD_HALVE_EN
      if (adv3) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_sum_q  <= s3_sum_d;
          s3_diff_q <= s3_diff_d;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mod_butterfly_pipe.sv
// Directed bench for mod_butterfly_pipe: Kyber 4-lane instance plus a 23-bit Dilithium instance.
module tb_mod_butterfly_pipe;
  localparam int W  = 12;
  localparam int L  = 4;
  localparam int LW = W * L;
  localparam int QK = 3329;
`ifdef MOD_HALVE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_mode, cur_halve;
  logic [LW-1:0] in_a, in_b;
  logic          out_valid, out_ready;
  logic [LW-1:0] out_sum, out_diff;

  logic          big_in_valid, big_in_ready, big_mode, big_halve;
  logic [22:0]   big_a, big_b, big_sum, big_diff;
  logic          big_out_valid, big_out_ready;

  int checks   = 0;
  int failures = 0;

  logic [2*LW-1:0] exp_q[$];
  logic [2*LW-1:0] cur_exp;
  logic [2*LW-1:0] hold_data;
  logic [2*LW-1:0] got;
  logic            hold = 1'b0;

  mod_butterfly_pipe #(.WIDTH(W), .Q(QK), .LANES(L)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b),
`ifdef MOD_HALVE_EN
    .in_halve(cur_halve),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_diff(out_diff)
  );

  mod_butterfly_pipe #(.WIDTH(23), .Q(8380417), .LANES(1)) u_big (
    .clk(clk), .rst_n(rst_n),
    .in_valid(big_in_valid), .in_ready(big_in_ready), .in_mode(big_mode),
    .in_a(big_a), .in_b(big_b),
`ifdef MOD_HALVE_EN
    .in_halve(big_halve),
`endif
    .out_valid(big_out_valid), .out_ready(big_out_ready),
    .out_sum(big_sum), .out_diff(big_diff)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboard: expected beats queued on acceptance, compared on output transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold) begin
        chk("hold_valid", 128'(out_valid), 128'(1));
        chk("hold_data", 128'({out_sum, out_diff}), 128'(hold_data));
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("out_sum", 128'(out_sum), 128'(got[2*LW-1:LW]));
          chk("out_diff", 128'(out_diff), 128'(got[LW-1:0]));
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = {out_sum, out_diff};
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end else begin
      hold = 1'b0;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [LW-1:0] a, input logic [LW-1:0] b, input logic mode,
                      input logic halve, input logic [LW-1:0] es, input logic [LW-1:0] ed);
    int t;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_mode   = mode;
    cur_halve = halve;
    cur_exp   = {es, ed};
    #1;
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    chk("send_accept", 128'(in_ready), 128'(1));
    step();
  endtask

  task automatic drain();
    int t;
    idle();
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  function automatic logic [LW-1:0] pack4(input int l3, input int l2, input int l1, input int l0);
    return {W'(l3), W'(l2), W'(l1), W'(l0)};
  endfunction

  function automatic logic [2*LW-1:0] model(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [LW-1:0] s, d;
    int x, y;
    for (int l = 0; l < L; l++) begin
      x = int'(a[l*W +: W]);
      y = int'(b[l*W +: W]);
      s[l*W +: W] = W'((x + y) % QK);
      d[l*W +: W] = W'((x - y + QK) % QK);
    end
    return {s, d};
  endfunction

  initial begin
    int nb;
    logic saw_stall, acc;

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; cur_halve = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1; cur_exp = '0;
    big_in_valid = 1'b0; big_mode = 1'b0; big_halve = 1'b0;
    big_a = '0; big_b = '0; big_out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_sum", 128'(out_sum), 128'(0));
    chk("rst_out_diff", 128'(out_diff), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // single beat, latency and hand values
    send(pack4(3328, 0, 5, 3000), pack4(3328, 0, 10, 1000), 1'b0, 1'b0,
         pack4(3327, 0, 15, 671), pack4(0, 0, 3324, 2000));
    idle();
    chk("lat_early", 128'(out_valid), 128'(0));
    repeat (LAT - 1) step();
    chk("lat_valid", 128'(out_valid), 128'(1));
    chk("lat_sum", 128'(out_sum), 128'(pack4(3327, 0, 15, 671)));
    chk("lat_diff", 128'(out_diff), 128'(pack4(0, 0, 3324, 2000)));
    drain();

    // back-to-back: bypass, wrap boundaries, repeat of first vector
    send(pack4(3328, 0, 7, 123), pack4(5, 3328, 9, 3000), 1'b1, 1'b0,
         pack4(3328, 0, 7, 123), pack4(5, 3328, 9, 3000));
    send(pack4(1664, 1, 3328, 0), pack4(1665, 3328, 1, 0), 1'b0, 1'b0,
         pack4(0, 0, 0, 0), pack4(3328, 2, 3327, 0));
    send(pack4(3328, 0, 5, 3000), pack4(3328, 0, 10, 1000), 1'b0, 1'b0,
         pack4(3327, 0, 15, 671), pack4(0, 0, 3324, 2000));
    drain();

    // ten-beat stream with downstream stall in cycles 3..5
    nb = 0;
    saw_stall = 1'b0;
    in_mode = 1'b0;
    cur_halve = 1'b0;
    for (int c = 0; c < 60 && (nb < 10 || exp_q.size() != 0); c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (nb < 10) begin
        in_valid = 1'b1;
        for (int l = 0; l < L; l++) begin
          in_a[l*W +: W] = W'(nb * 300 + l * 11);
          in_b[l*W +: W] = W'(l * 800 + nb * 50);
        end
        cur_exp = model(in_a, in_b);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (nb < 10 && !in_ready) saw_stall = 1'b1;
      acc = in_valid && in_ready;
      step();
      if (acc) nb++;
    end
    idle();
    chk("stream_stall_seen", 128'(saw_stall), 128'(1));
    chk("stream_beats", 128'(nb), 128'(10));
    drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    send(pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), 1'b0, 1'b0, pack4(5, 5, 5, 5), pack4(3326, 3328, 1, 3));
    send(pack4(9, 9, 9, 9), pack4(1, 1, 1, 1), 1'b0, 1'b0, pack4(10, 10, 10, 10), pack4(8, 8, 8, 8));
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    chk("rst2_out_valid", 128'(out_valid), 128'(0));
    chk("rst2_out_sum", 128'(out_sum), 128'(0));
    chk("rst2_out_diff", 128'(out_diff), 128'(0));
    chk("rst2_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    repeat (6) step();
    chk("rst2_no_stale", 128'(out_valid), 128'(0));

`ifdef MOD_HALVE_EN
    send(pack4(0, 0, 0, 1), pack4(0, 0, 0, 0), 1'b0, 1'b1, pack4(0, 0, 0, 1665), pack4(0, 0, 0, 1665));
    send(pack4(0, 0, 0, 4), pack4(0, 0, 0, 2), 1'b0, 1'b1, pack4(0, 0, 0, 3), pack4(0, 0, 0, 1));
    send(pack4(0, 0, 0, 4), pack4(0, 0, 0, 2), 1'b0, 1'b0, pack4(0, 0, 0, 6), pack4(0, 0, 0, 2));
    send(pack4(0, 0, 0, 1), pack4(0, 0, 0, 3), 1'b1, 1'b1, pack4(0, 0, 0, 1), pack4(0, 0, 0, 3));
    drain();
`endif

    // 23-bit Dilithium instance
    chk("big_in_ready", 128'(big_in_ready), 128'(1));
    big_in_valid = 1'b1;
    big_a = 23'd8380416;
    big_b = 23'd1;
    step();
    big_a = 23'd0;
    big_b = 23'd1;
    step();
    big_in_valid = 1'b0;
    repeat (LAT - 2) step();
    chk("big0_valid", 128'(big_out_valid), 128'(1));
    chk("big0_sum", 128'(big_sum), 128'(0));
    chk("big0_diff", 128'(big_diff), 128'(8380415));
    step();
    chk("big1_valid", 128'(big_out_valid), 128'(1));
    chk("big1_sum", 128'(big_sum), 128'(1));
    chk("big1_diff", 128'(big_diff), 128'(8380416));
    step();
    chk("big_idle", 128'(big_out_valid), 128'(0));

    // final report
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
